mux_arbiter: RTL and testbench
==============================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of both requesters and the output.
REQ-002 Parameter CNT_W, default 16, width of each per-requester grant counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in1_valid  input  1  requester 1 has data.
REQ-006 in1_data  input  WIDTH  requester 1 payload.
REQ-007 in1_ready  output  1  requester 1 payload accepted this cycle.
REQ-008 in2_valid  input  1  requester 2 has data.
REQ-009 in2_data  input  WIDTH  requester 2 payload.
REQ-010 in2_ready  output  1  requester 2 payload accepted this cycle.
REQ-011 sel  output  1  combinational mux select for the current cycle: 0 = in1, 1 = in2.
REQ-012 out_valid  output  1  output register holds a word.
REQ-013 out_data  output  WIDTH  registered selected payload.
REQ-014 out_src  output  1  source of out_data: 0 = in1, 1 = in2.
REQ-015 out_ready  input  1  consumer takes out_data this cycle.
REQ-016 cnt1, cnt2  output  CNT_W each  grants issued to in1 / in2.

Function
REQ-017 The block SHALL be a two-way round-robin arbiter feeding a one-entry output register through a WIDTH-bit 2:1 select.
REQ-018 State SHALL be two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 The slot SHALL be able to load when state is EMPTY, or when state is FULL and out_ready=1 (same-cycle drain and refill).
REQ-020 Priority pointer prio (0 = in1 first, 1 = in2 first) SHALL decide the grant when both valids are high; a single valid requester SHALL win regardless of prio.
REQ-021 sel SHALL equal the winning requester when the slot can load and at least one valid is high; otherwise sel SHALL hold its last registered value.
REQ-022 inN_ready SHALL be high only for the winner in a cycle where the slot can load; at most one ready SHALL be high per cycle.
REQ-023 Neither inN_ready SHALL depend combinationally on its own inN_data.
REQ-024 On a grant, out_data SHALL load the winner's data, out_src SHALL load sel, and out_valid SHALL be 1 on the next cycle (latency 1 cycle).
REQ-025 On a grant, prio SHALL point to the non-winner.
REQ-026 With no grant, prio SHALL hold.
REQ-027 FULL with out_ready=1 and no grant SHALL go to EMPTY.
REQ-028 FULL with out_ready=0 SHALL hold out_data and out_src stable, and both readies SHALL be 0.
REQ-029 cntN SHALL increment by 1 on each grant to requester N and wrap from 2^CNT_W-1 to 0.
REQ-030 A valid deasserted before it is granted SHALL be ignored with no side effects.
REQ-031 Sustained traffic on both inputs with out_ready=1 SHALL alternate grants every cycle.
REQ-032 No requester SHALL wait more than 2 load opportunities.

Reset
REQ-033 While rst=1 at a clock edge, the block SHALL set out_valid=0, out_data=0, out_src=0, sel=0, prio=0, cnt1=0, cnt2=0, and state EMPTY.
REQ-034 While rst=1, in1_ready and in2_ready SHALL be 0.
REQ-035 A word in flight when reset is applied SHALL be discarded.
REQ-036 In the first cycle after rst falls, the block SHALL arbitrate normally.

Verification
REQ-037 Stimulus: reset, then in1_valid=1, in1_data=7, in2_valid=0, out_ready=1. Required response: in1_ready=1, sel=0; next cycle out_valid=1, out_data=7, out_src=0, cnt1=1.
REQ-038 Stimulus: in1=7 and in2=13 both valid continuously, out_ready=1. Required response: out_data sequence 7,13,7,13; out_src 0,1,0,1; cnt1 and cnt2 each increment on alternate cycles.
REQ-039 Stimulus: FULL with out_data=19, out_ready=0 for 3 cycles, in2_valid=1, in2_data=23. Required response: out_data stays 19, in2_ready=0 throughout. Then out_ready=1: in2_ready=1 the same cycle, and out_data=23 on the next cycle with no bubble.
REQ-040 Stimulus: rst pulsed while FULL holding 13 with cnt2=5. Required response: out_valid=0, cnt2=0, prio=0; with both inputs valid afterward, in1 wins first.
REQ-041 Stimulus: CNT_W=4, 16 consecutive in1-only grants. Required response: cnt1 wraps to 0; cnt2 stays 0.
REQ-042 Stimulus: in2_valid pulsed for one cycle while out_ready=0. Required response: no grant, cnt2 unchanged, out_data unchanged.

Source files
------------

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-way round-robin arbiter in front of a one-entry output
// register. The slot refills in the same cycle it drains, so back-to-back
// traffic sees no bubbles. A per-requester grant counter tracks the grants
// issued to each input.
module mux_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  input  logic             in2_valid,
  input  logic [WIDTH-1:0] in2_data,
  output logic             in2_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state;
  logic             prio;
  logic             sel_q;
  logic             can_load;
  logic             grant;
  logic             win;
  logic [WIDTH-1:0] mux_data;

  // Arbitration. The readies are built from valids and state only, never
  // from the data buses, so a requester's ready has no path from its data.
  always_comb begin
    can_load  = (state == EMPTY) || out_ready;
    win       = in2_valid && (!in1_valid || prio);
    grant     = !rst && can_load && (in1_valid || in2_valid);
    sel       = grant ? win : sel_q;
    in1_ready = grant && !win;
    in2_ready = grant && win;
    mux_data  = win ? in2_data : in1_data;
  end

  assign out_valid = (state == FULL);

  // Slot, priority pointer and grant counters. A load takes precedence over
  // the drain-to-EMPTY path, which is how drain and refill share a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      prio     <= 1'b0;
      sel_q    <= 1'b0;
      out_data <= '0;
      out_src  <= 1'b0;
      cnt1     <= '0;
      cnt2     <= '0;
    end else if (grant) begin
      state    <= FULL;
      prio     <= !win;
      sel_q    <= win;
      out_data <= mux_data;
      out_src  <= win;
      if (win) cnt2 <= cnt2 + 1'b1;
      else     cnt1 <= cnt1 + 1'b1;
    end else if ((state == FULL) && out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: stimulus pushes the expected {src,data} of every
// granted word into a queue; a monitor pops and compares on each output
// transfer. Handshake and counter values are checked directly against
// hand-computed constants.
module tb_mux_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in1_valid = 1'b0, in2_valid = 1'b0, out_ready = 1'b0;
  logic [WIDTH-1:0] in1_data = '0, in2_data = '0;
  logic             in1_ready, in2_ready, sel, out_valid, out_src;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] cnt1, cnt2;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] sb[$];

  mux_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .in2_valid(in2_valid), .in2_data(in2_data), .in2_ready(in2_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .cnt1(cnt1), .cnt2(cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs just after the rising edge; settle 1 time unit.
  task automatic step(input logic v1, input int d1, input logic v2, input int d2,
                      input logic ordy);
    @(posedge clk); #1;
    rst = 1'b0;
    in1_valid = v1; in1_data = d1;
    in2_valid = v2; in2_data = d2;
    out_ready = ordy;
    #1;
  endtask

  task automatic push(input logic src, input int data);
    sb.push_back({src, data[WIDTH-1:0]});
  endtask

  // Hold reset for one edge with both requesters valid; the next step()
  // releases it together with its own inputs.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in1_valid = 1'b1; in1_data = 7;
    in2_valid = 1'b1; in2_data = 13;
    out_ready = 1'b0;
    sb.delete();
    #1;
    chk("rst_in1_ready", in1_ready, 0);
    chk("rst_in2_ready", in2_ready, 0);
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_sel", sel, 0);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_cnt2", cnt2, 0);
  endtask

  // Monitor: compare every transferred output word against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got src %0d data %0d expected no word", out_src, out_data);
      end else begin
        logic [WIDTH:0] e;
        e = sb.pop_front();
        chk("sb_src", out_src, e[WIDTH]);
        chk("sb_data", out_data, e[WIDTH-1:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single requester, basic latency.
    do_reset();
    step(1, 7, 0, 0, 1);
    chk("t1_in1_ready", in1_ready, 1);
    chk("t1_in2_ready", in2_ready, 0);
    chk("t1_sel", sel, 0);
    push(0, 7);
    step(0, 0, 0, 0, 1);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_src", out_src, 0);
    chk("t1_cnt1", cnt1, 1);

    // Both valid: alternate 7,13,7,13 starting from in1.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1, 7, 1, 13, 1);
      chk("t2_in1_ready", in1_ready, (k % 2 == 0) ? 1 : 0);
      chk("t2_in2_ready", in2_ready, (k % 2 == 1) ? 1 : 0);
      chk("t2_sel", sel, k % 2);
      if (k % 2 == 0) push(0, 7); else push(1, 13);
      if (k == 1) begin
        chk("t2_cnt1_mid", cnt1, 1);
        chk("t2_cnt2_mid", cnt2, 0);
      end
    end
    step(0, 0, 0, 0, 1);
    chk("t2_cnt1", cnt1, 2);
    chk("t2_cnt2", cnt2, 2);

    // Stall while FULL, then drain and refill in one cycle.
    step(1, 19, 0, 0, 0);
    chk("t3_load19", in1_ready, 1);
    push(0, 19);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 23, 0);
      chk("t3_stall_in2_ready", in2_ready, 0);
      chk("t3_stall_in1_ready", in1_ready, 0);
      chk("t3_stall_data", out_data, 19);
      chk("t3_stall_sel", sel, 0);
    end
    step(0, 0, 1, 23, 1);
    chk("t3_refill_in2_ready", in2_ready, 1);
    chk("t3_refill_sel", sel, 1);
    push(1, 23);
    step(0, 0, 0, 0, 0);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_out_data", out_data, 23);
    chk("t3_out_src", out_src, 1);

    // One-cycle in2 pulse while stalled: ignored.
    step(0, 0, 1, 29, 0);
    chk("t4_in2_ready", in2_ready, 0);
    step(0, 0, 0, 0, 0);
    chk("t4_cnt2", cnt2, 3);
    chk("t4_out_data", out_data, 23);

    // Build FULL holding 13 with cnt2=5, then reset mid-flight.
    step(0, 0, 1, 13, 1);
    chk("t5_g1", in2_ready, 1);
    push(1, 13);
    step(0, 0, 1, 13, 1);
    chk("t5_g2", in2_ready, 1);
    push(1, 13);
    step(0, 0, 0, 0, 0);
    chk("t5_hold13", out_data, 13);
    chk("t5_cnt2_5", cnt2, 5);
    do_reset();
    step(1, 7, 1, 13, 1);
    chk("t5_in1_first", in1_ready, 1);
    chk("t5_in2_wait", in2_ready, 0);
    chk("t5_sel", sel, 0);
    push(0, 7);
    step(0, 0, 0, 0, 1);
    chk("t5_cnt1", cnt1, 1);
    chk("t5_cnt2", cnt2, 0);

    // 16 in1-only grants wrap the 4-bit counter.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1, 100 + i, 0, 0, 1);
      chk("t6_in1_ready", in1_ready, 1);
      push(0, 100 + i);
      if (i == 15) chk("t6_cnt1_15", cnt1, 15);
    end
    step(0, 0, 0, 0, 1);
    chk("t6_cnt1_wrap", cnt1, 0);
    chk("t6_cnt2", cnt2, 0);
    step(0, 0, 0, 0, 1);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
